// File: rtl/johnson_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | johnson_counter: WIDTH-bit twisted-ring counter with phase decode, wrap   |
// | pulse and one-clock recovery from illegal codes.       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module johnson_counter #(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   count,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_oh,
  output logic               wrap,
  output logic               illegal
);

  localparam int            PWE        = PW + 1;
  localparam logic [PW:0]   CYCLE_LEN  = PWE'(2*WIDTH);
  localparam logic [PW-1:0] LAST_PHASE = PW'(2*WIDTH-1);

  logic [PW:0]      ones;
  logic [PW:0]      edges;
  logic [WIDTH-1:0] step_fwd;
  logic [WIDTH-1:0] step_rev;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH; i++)
      ones = ones + {{PW{1'b0}}, count[i]};
    for (int i = 0; i < WIDTH-1; i++)
      edges = edges + {{PW{1'b0}}, count[i] ^ count[i+1]};
  end

  assign illegal = (edges > PWE'(1));

  always_comb begin
    phase = '0;
    if (!illegal) begin
      if (count[WIDTH-1])
        phase = PW'(CYCLE_LEN - ones);
      else
        phase = ones[PW-1:0];
    end
  end

  always_comb begin
    phase_oh = '0;
    for (int k = 0; k < 2*WIDTH; k++)
      phase_oh[k] = !illegal && (phase == PW'(k));
  end

  assign step_fwd = {count[WIDTH-2:0], ~count[WIDTH-1]};
  assign step_rev = {~count[0], count[WIDTH-1:1]};

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_val;
    end else if (illegal) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = up ? step_fwd : step_rev;
      wrap_nxt  = up ? (phase == LAST_PHASE) : (phase == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_johnson_counter.sv
`default_nettype none
// tb_johnson_counter: scoreboard bench for johnson_counter at WIDTH=4; expected
// codes come from a reference sequence table, not from the counter's own logic.
module tb_johnson_counter;

  localparam int WIDTH = 4;
  localparam int PW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, up, clr, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    phase;
  logic [7:0]       phase_oh;
  logic             wrap;
  logic             illegal;

  johnson_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .phase    (phase),
    .phase_oh (phase_oh),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_count;
  logic [3:0] exp_count_q [$];
  logic       exp_wrap_q  [$];
  logic [3:0] e_c;
  logic       e_w;

  function automatic int idx_of(input logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (seq[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_phase(input logic [3:0] c);
    int i = idx_of(c);
    return (i < 0) ? 3'd0 : 3'(i);
  endfunction

  function automatic logic [7:0] exp_oh(input logic [3:0] c);
    int i = idx_of(c);
    return (i < 0) ? 8'h00 : (8'h01 << i);
  endfunction

  // Drives one cycle of stimulus, pushes the reference result, waits for the edge.
  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [3:0] lv);
    int         i;
    logic [3:0] nxt;
    logic       w;
    en = e; up = u; clr = c; load = l; load_val = lv;
    i = idx_of(m_count);
    w = 1'b0;
    if (c)           nxt = 4'b0000;
    else if (l)      nxt = lv;
    else if (i < 0)  nxt = 4'b0000;
    else if (e) begin
      if (u) begin nxt = seq[(i+1)%8]; w = (i == 7); end
      else   begin nxt = seq[(i+7)%8]; w = (i == 0); end
    end else         nxt = m_count;
    m_count = nxt;
    exp_count_q.push_back(nxt);
    exp_wrap_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    m_count = 4'b0000;
    #12;
    checks++;
    if (count !== 4'b0000 || wrap !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset count=%b wrap=%b illegal=%b expected 0000 0 0", count, wrap, illegal);
    end
    checks++;
    if (phase !== 3'd0 || phase_oh !== 8'h01) begin
      errors++;
      $display("FAIL reset_decode phase=%0d oh=%b expected 0 00000001", phase, phase_oh);
    end
    rst = 1'b1;
  endtask

  task automatic test_forward();
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
      checks++;
      if (count !== e_c || wrap !== e_w) begin
        errors++;
        $display("FAIL fwd[%0d] count=%b wrap=%b expected %b %b", n, count, wrap, e_c, e_w);
      end
      checks++;
      if (phase !== exp_phase(e_c) || phase_oh !== exp_oh(e_c) || illegal !== 1'b0) begin
        errors++;
        $display("FAIL fwd_decode[%0d] phase=%0d oh=%b ill=%b expected %0d %b 0",
                 n, phase, phase_oh, illegal, exp_phase(e_c), exp_oh(e_c));
      end
    end
  endtask

  task automatic test_reverse();
    for (int n = 0; n < 10; n++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
      checks++;
      if (count !== e_c || wrap !== e_w || phase !== exp_phase(e_c) || phase_oh !== exp_oh(e_c)) begin
        errors++;
        $display("FAIL rev[%0d] count=%b wrap=%b phase=%0d oh=%b expected %b %b %0d %b",
                 n, count, wrap, phase, phase_oh, e_c, e_w, exp_phase(e_c), exp_oh(e_c));
      end
    end
  endtask

  task automatic test_hold_direction();
    logic [2:0] ups = 3'b101;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0111);
    e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
    checks++;
    if (count !== e_c || wrap !== e_w) begin
      errors++;
      $display("FAIL hold_load count=%b wrap=%b expected %b %b", count, wrap, e_c, e_w);
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, n[0], 1'b0, 1'b0, 4'b0000);
      e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
      checks++;
      if (count !== e_c || wrap !== e_w) begin
        errors++;
        $display("FAIL hold[%0d] count=%b wrap=%b expected %b %b", n, count, wrap, e_c, e_w);
      end
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, ups[n], 1'b0, 1'b0, 4'b0000);
      e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
      checks++;
      if (count !== e_c || wrap !== e_w || phase !== exp_phase(e_c)) begin
        errors++;
        $display("FAIL dir_toggle[%0d] count=%b wrap=%b phase=%0d expected %b %b %0d",
                 n, count, wrap, phase, e_c, e_w, exp_phase(e_c));
      end
    end
  endtask

  task automatic test_load_clear();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b1100);
    e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
    checks++;
    if (count !== e_c || wrap !== e_w || phase !== 3'd6 || phase_oh !== 8'h40) begin
      errors++;
      $display("FAIL load count=%b wrap=%b phase=%0d oh=%b expected %b %b 6 01000000",
               count, wrap, phase, phase_oh, e_c, e_w);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1100);
    e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
    checks++;
    if (count !== e_c || wrap !== e_w || phase !== 3'd0) begin
      errors++;
      $display("FAIL clr_over_load count=%b wrap=%b phase=%0d expected %b %b 0",
               count, wrap, phase, e_c, e_w);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad [2] = '{4'b0101, 4'b0110};
    for (int n = 0; n < 2; n++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, bad[n]);
      e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
      checks++;
      if (count !== e_c || illegal !== 1'b1 || phase !== 3'd0 || phase_oh !== 8'h00) begin
        errors++;
        $display("FAIL illegal_load[%0d] count=%b ill=%b phase=%0d oh=%b expected %b 1 0 00000000",
                 n, count, illegal, phase, phase_oh, e_c);
      end
      drive(n[0], 1'b1, 1'b0, 1'b0, 4'b0000);
      e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
      checks++;
      if (count !== e_c || illegal !== 1'b0 || wrap !== e_w || phase_oh !== 8'h01) begin
        errors++;
        $display("FAIL illegal_recover[%0d] count=%b ill=%b wrap=%b oh=%b expected %b 0 %b 00000001",
                 n, count, illegal, wrap, phase_oh, e_c, e_w);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000);
    void'(exp_count_q.pop_front()); void'(exp_wrap_q.pop_front());
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
    checks++;
    if (count !== e_c || wrap !== e_w) begin
      errors++;
      $display("FAIL wrap_before_reset count=%b wrap=%b expected %b %b", count, wrap, e_c, e_w);
    end
    en = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if (wrap !== 1'b0 || count !== 4'b0000) begin
      errors++;
      $display("FAIL async_wrap count=%b wrap=%b expected 0000 0", count, wrap);
    end
    #1 rst = 1'b1;
    m_count = 4'b0000;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1110);
    e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
    checks++;
    if (count !== e_c) begin
      errors++;
      $display("FAIL pre_reset_load count=%b expected %b", count, e_c);
    end
    load = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if (count !== 4'b0000 || phase !== 3'd0 || phase_oh !== 8'h01 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset count=%b phase=%0d oh=%b wrap=%b expected 0000 0 00000001 0",
               count, phase, phase_oh, wrap);
    end
    #1 rst = 1'b1;
    m_count = 4'b0000;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    e_c = exp_count_q.pop_front(); e_w = exp_wrap_q.pop_front();
    checks++;
    if (count !== e_c || wrap !== e_w) begin
      errors++;
      $display("FAIL post_reset_step count=%b wrap=%b expected %b %b", count, wrap, e_c, e_w);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_hold_direction();
    test_load_clear();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
